rti_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_half_capture.sv | 34 +++
 rtl/rti_unit.sv | 157 +++++++++++++++
 tb/tb_rti_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction opcodes, RTI sequencer state encoding
// and datapath width defaults used by the interrupt entry/exit logic.
package cpu_pkg;

  localparam int DEF_PC_WIDTH   = 32;
  localparam int DEF_HALF_WIDTH = 16;
  localparam int DEF_WAIT_MAX   = 15;

  // Stack opcodes: bit 3 selects pop (1) vs push (0), low bits pick the register.
  localparam logic [15:0] OP_NOP      = 16'h0000;
  localparam logic [15:0] OP_PUSH_PCL = 16'h7000;
  localparam logic [15:0] OP_PUSH_PCH = 16'h7001;
  localparam logic [15:0] OP_PUSH_CCR = 16'h7002;
  localparam logic [15:0] OP_POP_PCL  = 16'h7008;
  localparam logic [15:0] OP_POP_PCH  = 16'h7009;
  localparam logic [15:0] OP_POP_CCR  = 16'h700A;

  typedef enum logic [2:0] {
    RTI_IDLE    = 3'd0,
    RTI_FLUSH   = 3'd1,
    RTI_POP_PCH = 3'd2,
    RTI_POP_PCL = 3'd3,
    RTI_POP_CCR = 3'd4,
    RTI_WAIT_WB = 3'd5,
    RTI_PC_LOAD = 3'd6
  } rti_state_t;

endpackage

// File: rtl/pc_half_capture.sv
// Holds one popped PC half from the write-back bus plus a "got it" flag.
// A clear request always wins over a capture in the same cycle.
module pc_half_capture #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         capture_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         got_o
);

  logic [W-1:0] data_q;
  logic         got_q;

  // Capture register and its valid flag; flag cleared at sequence start or disable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      got_q  <= 1'b0;
    end else if (clear_i) begin
      got_q  <= 1'b0;
    end else if (capture_i) begin
      data_q <= data_i;
      got_q  <= 1'b1;
    end
  end

  assign data_o = data_q;
  assign got_o  = got_q;

endmodule

// File: rtl/rti_unit.sv
// Return-from-interrupt sequencer. On an RTI in decode it stalls fetch,
// injects POP PCH / POP PCL / POP CCR, collects the two popped PC halves from
// write-back and fires a single-cycle PC load. A bounded wait for the halves
// raises a sticky error instead of hanging the pipeline.
module rti_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int HALF_WIDTH = DEF_HALF_WIDTH,
  parameter int WAIT_MAX   = DEF_WAIT_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rti_req,
  input  logic                  wb_hi_valid,
  input  logic                  wb_lo_valid,
  input  logic [HALF_WIDTH-1:0] wb_data,
  output logic                  stall,
  output logic                  instr_valid,
  output logic [HALF_WIDTH-1:0] instruction,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   PC_VALUE,
  output logic                  rti_busy,
  output logic                  rti_done,
  output logic                  rti_err
);

  // Last counter value still inside the wait window; reaching WAIT_MAX times out.
  localparam logic [3:0] TMO_LAST = 4'(WAIT_MAX - 1);

  rti_state_t            state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;

  logic                  in_seq;
  logic                  flush_entry;
  logic                  clear_caps;
  logic                  hi_got, lo_got;
  logic [HALF_WIDTH-1:0] hi_data, lo_data;
  logic                  hi_avail, lo_avail;

  assign in_seq      = (state_q != RTI_IDLE);
  assign flush_entry = enable && (state_q == RTI_IDLE) && rti_req;
  assign clear_caps  = flush_entry || !enable;

  pc_half_capture #(.W(HALF_WIDTH)) u_hi_cap (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear_caps),
    .capture_i (wb_hi_valid && in_seq),
    .data_i    (wb_data),
    .data_o    (hi_data),
    .got_o     (hi_got)
  );

  pc_half_capture #(.W(HALF_WIDTH)) u_lo_cap (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear_caps),
    .capture_i (wb_lo_valid && in_seq),
    .data_i    (wb_data),
    .data_o    (lo_data),
    .got_o     (lo_got)
  );

  // A half arriving on the same edge counts, so PC_LOAD is not delayed a cycle.
  assign hi_avail = hi_got || wb_hi_valid;
  assign lo_avail = lo_got || wb_lo_valid;

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RTI_IDLE;
      wait_cnt_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic, wait timeout and error flag update.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (!enable) begin
      state_d = RTI_IDLE;
    end else begin
      unique case (state_q)
        RTI_IDLE:    if (rti_req) state_d = RTI_FLUSH;
        RTI_FLUSH:   state_d = RTI_POP_PCH;
        RTI_POP_PCH: state_d = RTI_POP_PCL;
        RTI_POP_PCL: state_d = RTI_POP_CCR;
        RTI_POP_CCR: begin
          state_d    = RTI_WAIT_WB;
          wait_cnt_d = 4'd0;
        end
        RTI_WAIT_WB: begin
          if (hi_avail && lo_avail) begin
            state_d = RTI_PC_LOAD;
          end else if (wait_cnt_q == TMO_LAST) begin
            state_d = RTI_IDLE;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        RTI_PC_LOAD: state_d = RTI_IDLE;
        default:     state_d = RTI_IDLE;
      endcase
    end
  end

  // Moore output decode from the current state.
  always_comb begin
    stall       = 1'b0;
    instr_valid = 1'b0;
    instruction = HALF_WIDTH'(OP_NOP);
    pc_load     = 1'b0;
    unique case (state_q)
      RTI_IDLE: ;
      RTI_FLUSH, RTI_WAIT_WB: begin
        stall       = 1'b1;
        instr_valid = 1'b1;
      end
      RTI_POP_PCH: begin
        stall       = 1'b1;
        instr_valid = 1'b1;
        instruction = HALF_WIDTH'(OP_POP_PCH);
      end
      RTI_POP_PCL: begin
        stall       = 1'b1;
        instr_valid = 1'b1;
        instruction = HALF_WIDTH'(OP_POP_PCL);
      end
      RTI_POP_CCR: begin
        stall       = 1'b1;
        instr_valid = 1'b1;
        instruction = HALF_WIDTH'(OP_POP_CCR);
      end
      RTI_PC_LOAD: begin
        instr_valid = 1'b1;
        pc_load     = 1'b1;
      end
      default: ;
    endcase
  end

  assign rti_busy = in_seq;
  assign rti_done = pc_load;
  assign rti_err  = err_q;
  assign PC_VALUE = pc_load ? PC_WIDTH'({hi_data, lo_data}) : '0;

endmodule

// File: tb/tb_rti_unit.sv
// Directed bench for rti_unit: table-driven cycle vectors plus hand-written
// reset and timeout sequences. Each table row gives the inputs held during one
// cycle and the outputs expected in the cycle after the next rising edge.
module tb_rti_unit;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] PCH = 16'h7009;
  localparam logic [15:0] PCL = 16'h7008;
  localparam logic [15:0] CCR = 16'h700A;

  typedef enum int {K_IDLE, K_FLUSH, K_PCH, K_PCL, K_CCR, K_WAIT, K_LOAD} kind_t;

  typedef struct packed {
    logic        stall;
    logic        iv;
    logic [15:0] instr;
    logic        pcl;
    logic [31:0] pcv;
    logic        busy;
    logic        done;
    logic        err;
  } out_t;

  typedef struct {
    logic        en;
    logic        req;
    logic        hv;
    logic        lv;
    logic [15:0] d;
    kind_t       kind;
    logic [31:0] pcv;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        rti_req = 1'b0;
  logic        wb_hi_valid = 1'b0;
  logic        wb_lo_valid = 1'b0;
  logic [15:0] wb_data = 16'h0000;
  logic        stall, instr_valid, pc_load, rti_busy, rti_done, rti_err;
  logic [15:0] instruction;
  logic [31:0] PC_VALUE;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  rti_unit dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rti_req     (rti_req),
    .wb_hi_valid (wb_hi_valid),
    .wb_lo_valid (wb_lo_valid),
    .wb_data     (wb_data),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc_load     (pc_load),
    .PC_VALUE    (PC_VALUE),
    .rti_busy    (rti_busy),
    .rti_done    (rti_done),
    .rti_err     (rti_err)
  );

  always #5 clk = ~clk;

  function automatic out_t exp_of(kind_t k, logic [31:0] pcv, logic err);
    out_t o;
    o = '{stall: 1'b0, iv: 1'b0, instr: NOP, pcl: 1'b0, pcv: 32'h0,
          busy: 1'b0, done: 1'b0, err: err};
    case (k)
      K_IDLE:  ;
      K_FLUSH: begin o.stall = 1'b1; o.iv = 1'b1; o.busy = 1'b1; end
      K_PCH:   begin o.stall = 1'b1; o.iv = 1'b1; o.busy = 1'b1; o.instr = PCH; end
      K_PCL:   begin o.stall = 1'b1; o.iv = 1'b1; o.busy = 1'b1; o.instr = PCL; end
      K_CCR:   begin o.stall = 1'b1; o.iv = 1'b1; o.busy = 1'b1; o.instr = CCR; end
      K_WAIT:  begin o.stall = 1'b1; o.iv = 1'b1; o.busy = 1'b1; end
      K_LOAD:  begin o.iv = 1'b1; o.busy = 1'b1; o.pcl = 1'b1; o.done = 1'b1; o.pcv = pcv; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = '{stall: stall, iv: instr_valid, instr: instruction, pcl: pc_load,
          pcv: PC_VALUE, busy: rti_busy, done: rti_done, err: rti_err};
    return o;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got stall=%b iv=%b instr=%h pc_load=%b pc=%h busy=%b done=%b err=%b, want stall=%b iv=%b instr=%h pc_load=%b pc=%h busy=%b done=%b err=%b",
               name, act.stall, act.iv, act.instr, act.pcl, act.pcv, act.busy, act.done, act.err,
               exp.stall, exp.iv, exp.instr, exp.pcl, exp.pcv, exp.busy, exp.done, exp.err);
    end else begin
      $display("ok   %s: instr=%h pc_load=%b pc=%h busy=%b err=%b",
               name, act.instr, act.pcl, act.pcv, act.busy, act.err);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic en, input logic req, input logic hv,
                     input logic lv, input logic [15:0] d, input kind_t k, input logic [31:0] pcv);
    vec_t v;
    v.en = en; v.req = req; v.hv = hv; v.lv = lv; v.d = d;
    v.kind = k; v.pcv = pcv; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic apply_rows(input int first, input int last, input logic err_exp);
    for (int i = first; i < last; i++) begin
      enable      = vecs[i].en;
      rti_req     = vecs[i].req;
      wb_hi_valid = vecs[i].hv;
      wb_lo_valid = vecs[i].lv;
      wb_data     = vecs[i].d;
      step();
      chk(vecs[i].name, exp_of(vecs[i].kind, vecs[i].pcv, err_exp));
    end
    enable = 1'b1; rti_req = 1'b0; wb_hi_valid = 1'b0; wb_lo_valid = 1'b0; wb_data = 16'h0;
  endtask

  initial begin
    int t2_s, t2_e, t3_s, t3_e, t6_s, t6_e, t5_s, t5_e;

    // Split WB: hi in cycle 5, lo in cycle 6, load in cycle 7.
    t2_s = vecs.size();
    add("split_c1_flush", 1, 1, 0, 0, 16'h0000, K_FLUSH, 0);
    add("split_c2_pch",   1, 0, 0, 0, 16'h0000, K_PCH,   0);
    add("split_c3_pcl",   1, 0, 0, 0, 16'h0000, K_PCL,   0);
    add("split_c4_ccr",   1, 0, 0, 0, 16'h0000, K_CCR,   0);
    add("split_c5_wait",  1, 0, 0, 0, 16'h0000, K_WAIT,  0);
    add("split_c6_wait",  1, 0, 1, 0, 16'h0000, K_WAIT,  0);
    add("split_c7_load",  1, 0, 0, 1, 16'h0123, K_LOAD,  32'h0000_0123);
    add("split_c8_idle",  1, 0, 0, 0, 16'h0000, K_IDLE,  0);
    t2_e = vecs.size();

    // Both halves captured during the POP states: earliest load in cycle 6.
    t3_s = vecs.size();
    add("early_c1_flush", 1, 1, 0, 0, 16'h0000, K_FLUSH, 0);
    add("early_c2_pch",   1, 0, 0, 0, 16'h0000, K_PCH,   0);
    add("early_c3_pcl",   1, 0, 1, 0, 16'hABCD, K_PCL,   0);
    add("early_c4_ccr",   1, 0, 0, 1, 16'h1234, K_CCR,   0);
    add("early_c5_wait",  1, 0, 0, 0, 16'h0000, K_WAIT,  0);
    add("early_c6_load",  1, 0, 0, 0, 16'h0000, K_LOAD,  32'hABCD_1234);
    add("early_c7_idle",  1, 0, 0, 0, 16'h0000, K_IDLE,  0);
    t3_e = vecs.size();

    // Enable dropped in POP_PCH, then a fresh RTI with new halves (lo first).
    t6_s = vecs.size();
    add("dis_c1_flush",   1, 1, 0, 0, 16'h0000, K_FLUSH, 0);
    add("dis_c2_pch",     1, 0, 1, 0, 16'h5555, K_PCH,   0);
    add("dis_c3_idle",    0, 0, 0, 1, 16'h6666, K_IDLE,  0);
    add("dis_c4_idle",    1, 0, 0, 0, 16'h0000, K_IDLE,  0);
    add("dis_r_flush",    1, 1, 0, 0, 16'h0000, K_FLUSH, 0);
    add("dis_r_pch",      1, 0, 0, 0, 16'h0000, K_PCH,   0);
    add("dis_r_pcl",      1, 0, 0, 0, 16'h0000, K_PCL,   0);
    add("dis_r_ccr",      1, 0, 0, 0, 16'h0000, K_CCR,   0);
    add("dis_r_wait1",    1, 0, 0, 1, 16'h2222, K_WAIT,  0);
    add("dis_r_wait2",    1, 0, 0, 0, 16'h0000, K_WAIT,  0);
    add("dis_r_load",     1, 0, 1, 0, 16'h1111, K_LOAD,  32'h1111_2222);
    add("dis_r_idle",     1, 0, 0, 0, 16'h0000, K_IDLE,  0);
    t6_e = vecs.size();

    // rti_req held: two sequences separated by exactly one IDLE cycle.
    t5_s = vecs.size();
    add("held_a_flush",   1, 1, 0, 0, 16'h0000, K_FLUSH, 0);
    add("held_a_pch",     1, 1, 1, 0, 16'hAAAA, K_PCH,   0);
    add("held_a_pcl",     1, 1, 0, 1, 16'hBBBB, K_PCL,   0);
    add("held_a_ccr",     1, 1, 0, 0, 16'h0000, K_CCR,   0);
    add("held_a_wait",    1, 1, 0, 0, 16'h0000, K_WAIT,  0);
    add("held_a_load",    1, 1, 0, 0, 16'h0000, K_LOAD,  32'hAAAA_BBBB);
    add("held_gap_idle",  1, 1, 0, 0, 16'h0000, K_IDLE,  0);
    add("held_b_flush",   1, 1, 0, 0, 16'h0000, K_FLUSH, 0);
    add("held_b_pch",     1, 1, 1, 0, 16'h0C0C, K_PCH,   0);
    add("held_b_pcl",     1, 1, 0, 1, 16'h0D0D, K_PCL,   0);
    add("held_b_ccr",     1, 1, 0, 0, 16'h0000, K_CCR,   0);
    add("held_b_wait",    1, 1, 0, 0, 16'h0000, K_WAIT,  0);
    add("held_b_load",    1, 0, 0, 0, 16'h0000, K_LOAD,  32'h0C0C_0D0D);
    add("held_b_idle",    1, 0, 0, 0, 16'h0000, K_IDLE,  0);
    t5_e = vecs.size();

    // Reset values while reset is held.
    step();
    step();
    chk("reset_state", exp_of(K_IDLE, 0, 1'b0));
    reset = 1'b1;
    step();
    chk("post_reset_idle", exp_of(K_IDLE, 0, 1'b0));

    // Reset asserted mid-POP_PCL: outputs drop immediately, no pc_load afterwards.
    rti_req = 1'b1;
    step();
    rti_req = 1'b0;
    step();
    step();
    chk("rst_seq_pcl", exp_of(K_PCL, 0, 1'b0));
    #2 reset = 1'b0;
    #1 chk("rst_async_drop", exp_of(K_IDLE, 0, 1'b0));
    step();
    chk("rst_held_idle", exp_of(K_IDLE, 0, 1'b0));
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rst_after_%0d", i), exp_of(K_IDLE, 0, 1'b0));
    end

    apply_rows(t2_s, t2_e, 1'b0);
    apply_rows(t3_s, t3_e, 1'b0);
    apply_rows(t6_s, t6_e, 1'b0);
    apply_rows(t5_s, t5_e, 1'b0);

    // Timeout: no write-back; 15 WAIT_WB cycles (5..19), IDLE with rti_err in cycle 20.
    rti_req = 1'b1;
    step();
    chk("tmo_c1_flush", exp_of(K_FLUSH, 0, 1'b0));
    rti_req = 1'b0;
    step(); chk("tmo_c2_pch", exp_of(K_PCH, 0, 1'b0));
    step(); chk("tmo_c3_pcl", exp_of(K_PCL, 0, 1'b0));
    step(); chk("tmo_c4_ccr", exp_of(K_CCR, 0, 1'b0));
    for (int c = 5; c <= 19; c++) begin
      step();
      chk($sformatf("tmo_c%0d_wait", c), exp_of(K_WAIT, 0, 1'b0));
    end
    step();
    chk("tmo_c20_err_idle", exp_of(K_IDLE, 0, 1'b1));
    step();
    chk("tmo_c21_idle", exp_of(K_IDLE, 0, 1'b1));

    // A good RTI afterwards still completes while rti_err stays set.
    apply_rows(t3_s, t3_e, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
